// File: rtl/mux_rr_arb.sv
// N-channel registered multiplexer with fixed-select or round-robin arbitration.
// Latency: one cycle from input handshake (in_valid & in_ready) to out_valid.
// Backpressure: a held, unconsumed output word (out_ready low) blocks all grants.
module mux_rr_arb #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    // N and the last channel index, expressed in the index widths used below
    localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST  = SELW'(N-1);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [SELW-1:0]  ch_q;
    logic [SELW-1:0]  ptr_q;
    logic [SELW-1:0]  ptr_d;

    logic             load_en;
    logic             rr_hit;
    logic [SELW-1:0]  rr_idx;
    logic             fx_ok;
    logic             grant;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_word;

    // The output register can take a word when it is empty or being drained now
    assign load_en = !valid_q || out_ready;

    // Round-robin scan starting at ptr; ptr is always below N so one subtract wraps
    always_comb begin
        logic [SELW:0] cand;
        cand   = '0;
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (SELW+1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!rr_hit && in_valid[cand[SELW-1:0]]) begin
                rr_hit = 1'b1;
                rr_idx = cand[SELW-1:0];
            end
        end
    end

    // Fixed mode: an out-of-range sel never grants
    assign fx_ok = ({1'b0, sel} < N_EXT) && in_valid[sel];

    // Pick the candidate for the current mode; nothing is granted during reset or stall
    always_comb begin
        gnt_idx = mode ? rr_idx : sel;
        grant   = (mode ? rr_hit : fx_ok) && load_en && !reset;
    end

    // One-hot ready toward the granted producer only
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = grant && (gnt_idx == SELW'(i));
        end
    end

    // Select the granted channel's word
    always_comb begin
        gnt_word = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer advances past the winner only on round-robin grants
    always_comb begin
        ptr_d = ptr_q;
        if (grant && mode) begin
            ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Output register: load on grant, otherwise drain on out_ready, else hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (grant) begin
                data_q  <= gnt_word;
                ch_q    <= gnt_idx;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Outputs come straight from the registers and clear with the async reset
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Bench for mux_rr_arb: a 4-channel and a 3-channel instance run in lockstep.
// Each is compared against a queue-free behavioural model of the selection rules.
// Directed phases follow the usage scenarios, then randomized traffic.
module tb_mux_rr_arb;

    logic        clk = 1'b0;
    logic        reset;

    logic        mode4, mode3;
    logic [1:0]  sel4, sel3;
    logic [15:0] din4;
    logic [11:0] din3;
    logic [3:0]  vld4, rdy4;
    logic [2:0]  vld3, rdy3;
    logic [3:0]  dout4, dout3;
    logic        ov4, ov3, ordy4, ordy3;
    logic [1:0]  och4, och3;

    always #5 clk = ~clk;

    mux_rr_arb #(.WIDTH(4), .N(4), .SELW(2)) dut4 (
        .clk(clk), .reset(reset), .mode(mode4), .sel(sel4),
        .in_data(din4), .in_valid(vld4), .in_ready(rdy4),
        .out_data(dout4), .out_valid(ov4), .out_ready(ordy4), .out_ch(och4)
    );

    mux_rr_arb #(.WIDTH(4), .N(3), .SELW(2)) dut3 (
        .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
        .in_data(din3), .in_valid(vld3), .in_ready(rdy3),
        .out_data(dout3), .out_valid(ov3), .out_ready(ordy3), .out_ch(och3)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model state per instance: index 0 is the N=4 block, 1 the N=3 block
    int mv[2];
    int md[2];
    int mc[2];
    int mp[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Which channel is taken this cycle, or -1 if none
    function automatic int pick(int n, logic m, int s, logic [3:0] v, int ptr, int ov, logic ordy);
        if (ov != 0 && !ordy) return -1;
        if (!m) return (s < n && v[s]) ? s : -1;
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic void upd(int d, int n, int g, logic m, logic [15:0] din, logic ordy);
        if (g >= 0) begin
            mv[d] = 1;
            md[d] = int'(din[g*4 +: 4]);
            mc[d] = g;
            if (m) mp[d] = (g + 1) % n;
        end else if (ordy) begin
            mv[d] = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 0; md[d] = 0; mc[d] = 0; mp[d] = 0;
        end
    endfunction

    // One clock: check ready before the edge, outputs after it
    task automatic step(input string tag);
        int g4, g3;
        #1;
        g4 = pick(4, mode4, int'(sel4), vld4, mp[0], mv[0], ordy4);
        g3 = pick(3, mode3, int'(sel3), {1'b0, vld3}, mp[1], mv[1], ordy3);
        chk({tag, ".rdy4"}, 32'(rdy4), (g4 >= 0) ? (32'd1 << g4) : 32'd0);
        chk({tag, ".rdy3"}, 32'(rdy3), (g3 >= 0) ? (32'd1 << g3) : 32'd0);
        @(posedge clk);
        #1;
        upd(0, 4, g4, mode4, din4, ordy4);
        upd(1, 3, g3, mode3, {4'b0, din3}, ordy3);
        chk({tag, ".ov4"}, 32'(ov4), 32'(mv[0]));
        chk({tag, ".ov3"}, 32'(ov3), 32'(mv[1]));
        chk({tag, ".dout4"}, 32'(dout4), 32'(md[0]));
        chk({tag, ".dout3"}, 32'(dout3), 32'(md[1]));
        chk({tag, ".och4"}, 32'(och4), 32'(mc[0]));
        chk({tag, ".och3"}, 32'(och3), 32'(mc[1]));
    endtask

    initial begin
        int seq4[6];
        int alt4[4];
        int seq3[4];
        seq4 = '{0, 1, 2, 3, 0, 1};
        alt4 = '{3, 1, 3, 1};
        seq3 = '{0, 1, 2, 0};

        // Power-on reset with requests present: nothing may be granted
        reset = 1'b1;
        mode4 = 1'b0; sel4 = 2'd0; din4 = '0; vld4 = 4'hF; ordy4 = 1'b1;
        mode3 = 1'b1; sel3 = 2'd0; din3 = '0; vld3 = 3'h7; ordy3 = 1'b1;
        model_reset();
        #2;
        chk("por.ov4", 32'(ov4), 32'd0);
        chk("por.dout4", 32'(dout4), 32'd0);
        chk("por.och4", 32'(och4), 32'd0);
        chk("por.rdy4", 32'(rdy4), 32'd0);
        chk("por.rdy3", 32'(rdy3), 32'd0);
        @(posedge clk);
        #1;
        chk("por.edge.ov4", 32'(ov4), 32'd0);
        chk("por.edge.ov3", 32'(ov3), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        vld4 = '0; vld3 = '0;

        // Load 4'hA into a stalled output, then reset mid-cycle
        din4 = 16'h000A; vld4 = 4'b0001; ordy4 = 1'b0;
        din3 = 12'h005;  vld3 = 3'b001;  ordy3 = 1'b0;
        step("load");
        chk("load.a", 32'(dout4), 32'hA);
        vld4 = 4'hF; vld3 = 3'h7;
        #3;
        reset = 1'b1;
        #1;
        chk("mid.ov4", 32'(ov4), 32'd0);
        chk("mid.dout4", 32'(dout4), 32'd0);
        chk("mid.och4", 32'(och4), 32'd0);
        chk("mid.rdy4", 32'(rdy4), 32'd0);
        chk("mid.ov3", 32'(ov3), 32'd0);
        chk("mid.rdy3", 32'(rdy3), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Fixed select of channel 2 on the 4-channel block; 3-channel block rotates
        mode4 = 1'b0; sel4 = 2'd2; din4 = 16'h4321; vld4 = 4'hF; ordy4 = 1'b1;
        mode3 = 1'b1; din3 = 12'h321; vld3 = 3'h7; ordy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("fix");
            chk("fix.data", 32'(dout4), 32'd3);
            chk("fix.ch", 32'(och4), 32'd2);
            chk("rr3.seq", 32'(och3), 32'(seq3[i]));
        end

        // Round-robin over all four, then over the two odd channels
        mode4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("rr");
            chk("rr.seq", 32'(och4), 32'(seq4[i]));
        end
        vld4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step("rr2");
            chk("rr2.seq", 32'(och4), 32'(alt4[i]));
        end

        // Backpressure: hold a 7 for three cycles with every channel requesting
        vld4 = 4'hF; din4 = 16'h7777;
        step("bp.load");
        din4 = 16'h9ABC; ordy4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("bp");
            chk("bp.hold", 32'(dout4), 32'd7);
        end
        ordy4 = 1'b1;
        step("bp.rel");
        step("bp.rel");

        // Drain both blocks, then resume to confirm the pointer stayed put
        vld4 = '0; vld3 = '0;
        step("drain");
        step("drain");
        chk("drain.empty", 32'(ov4), 32'd0);
        vld4 = 4'hF; vld3 = 3'h7;
        step("resume");

        // Out-of-range fixed select on the 3-channel block
        mode3 = 1'b0; sel3 = 2'd3;
        step("sel3");
        chk("sel3.empty", 32'(ov3), 32'd0);
        step("sel3");

        // Randomized traffic on both blocks
        for (int i = 0; i < 500; i++) begin
            mode4 = 1'($urandom); sel4 = 2'($urandom); din4 = 16'($urandom);
            vld4 = 4'($urandom); ordy4 = ($urandom_range(0, 3) != 0);
            mode3 = 1'($urandom); sel3 = 2'($urandom); din3 = 12'($urandom);
            vld3 = 3'($urandom); ordy3 = ($urandom_range(0, 3) != 0);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
